// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use hazard detection and bubble insertion.
//
// A bubble (EX_ctrl = 0, EX_valid = 0, data fields held) is inserted when EX_flush is
// high or when a load in EX feeds the instruction in ID. bubble_cnt counts inserted
// bubbles and saturates at all-ones.
//
// Build option: LOAD_USE_STALL_EN
//   defined   -> load-use detection drives stall; HOLD_CHK state present.
//   undefined -> stall is tied low; only EX_flush creates bubbles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal update; last edge loaded ID into EX
// BUBBLE   | last edge inserted a flush bubble
// HOLD_CHK | last edge inserted a stall bubble; held ID is re-evaluated now
//            (only present with LOAD_USE_STALL_EN)

module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [13:0]       ID_ctrl,
  input  logic              ID_valid,
  input  logic [DATA_W-1:0] ID_rs_data,
  input  logic [DATA_W-1:0] ID_rt_data,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic [4:0]        ID_rd,
  input  logic [4:0]        ID_shamt,

  input  logic              EX_flush,

  output logic [13:0]       EX_ctrl,
  output logic              EX_valid,
  output logic [DATA_W-1:0] EX_rs_data,
  output logic [DATA_W-1:0] EX_rt_data,
  output logic [DATA_W-1:0] EX_imm,
  output logic [DATA_W-1:0] EX_PC4,
  output logic [4:0]        EX_rs,
  output logic [4:0]        EX_rt,
  output logic [4:0]        EX_rd,
  output logic [4:0]        EX_shamt,

  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Decode bundle bit positions used by the hazard check.
  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 2;
  localparam int ALU_SRC2_BIT  = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1
`ifdef LOAD_USE_STALL_EN
    ,
    HOLD_CHK = 2'd2
`endif
  } state_t;

  state_t state;
  state_t stateNext;
  logic   bubble;

`ifdef LOAD_USE_STALL_EN
  logic loadUse;
  logic rsHit;
  logic rtHit;
  logic rtNeeded;

  // Load in EX whose destination is read by the instruction in ID.
  // rt is only a true source when the ALU takes it (ALUSrc2 = 0) or a store writes it.
  always_comb begin
    rsHit    = (EX_rt == ID_rs);
    rtNeeded = ~ID_ctrl[ALU_SRC2_BIT] | ID_ctrl[MEM_WRITE_BIT];
    rtHit    = (EX_rt == ID_rt) & rtNeeded;
    loadUse  = EX_valid & EX_ctrl[MEM_READ_BIT] & (EX_rt != 5'd0) & ID_valid
               & (rsHit | rtHit);
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: a flush dominates a simultaneous stall (both give one bubble).
  always_comb begin
    stateNext = RUN;
    case (state)
      RUN, BUBBLE: begin
        if (EX_flush) begin
          stateNext = BUBBLE;
        end
`ifdef LOAD_USE_STALL_EN
        else if (stall) begin
          stateNext = HOLD_CHK;
        end
`endif
        else begin
          stateNext = RUN;
        end
      end
`ifdef LOAD_USE_STALL_EN
      // The stall bubble cleared EX, so the held ID instruction cannot stall again.
      HOLD_CHK: begin
        if (EX_flush) begin
          stateNext = BUBBLE;
        end else begin
          stateNext = RUN;
        end
      end
`endif
      default: stateNext = RUN;
    endcase
  end

  // Output logic: stall request and bubble decision for the coming edge.
  always_comb begin
    stall = 1'b0;
`ifdef LOAD_USE_STALL_EN
    stall = loadUse & (state != HOLD_CHK);
`endif
    bubble = EX_flush | stall;
  end

  // Control half of the pipeline register: cleared on a bubble or an empty ID slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_ctrl  <= '0;
      EX_valid <= 1'b0;
    end else if (bubble) begin
      EX_ctrl  <= '0;
      EX_valid <= 1'b0;
    end else begin
      EX_ctrl  <= ID_valid ? ID_ctrl : 14'd0;
      EX_valid <= ID_valid;
    end
  end

  // Data half of the pipeline register: holds across a bubble, loads otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_rs_data <= '0;
      EX_rt_data <= '0;
      EX_imm     <= '0;
      EX_PC4     <= '0;
      EX_rs      <= '0;
      EX_rt      <= '0;
      EX_rd      <= '0;
      EX_shamt   <= '0;
    end else if (!bubble) begin
      EX_rs_data <= ID_rs_data;
      EX_rt_data <= ID_rt_data;
      EX_imm     <= ID_imm;
      EX_PC4     <= ID_PC4;
      EX_rs      <= ID_rs;
      EX_rt      <= ID_rt;
      EX_rd      <= ID_rd;
      EX_shamt   <= ID_shamt;
    end
  end

  // Saturating bubble counter; a simultaneous stall and flush is one bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, 32: width of operand, immediate and PC fields.
REQ-002 Parameter CNT_W, 16: width of the bubble counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 ID_ctrl  in  14  packed decode bundle: [0]RegWrite [1]MemRead [2]MemWrite [4:3]MemtoReg [6:5]RegDst [7]ALUSrc1 [8]ALUSrc2 [12:9]ALUOp [13]Branch.
REQ-006 ID_valid  in  1  ID holds a real instruction.
REQ-007 ID_rs_data, ID_rt_data, ID_imm, ID_PC4  in  DATA_W each  read operands, extended immediate, PC+4.
REQ-008 ID_rs, ID_rt, ID_rd, ID_shamt  in  5 each  register specifiers and shift amount.
REQ-009 EX_flush  in  1  branch/jump resolved taken; kill the instruction entering EX.
REQ-010 EX_ctrl, EX_valid, EX_rs_data, EX_rt_data, EX_imm, EX_PC4, EX_rs, EX_rt, EX_rd, EX_shamt  out  (widths match ID_ counterparts)  registered copies.
REQ-011 stall  out  1  combinational; holds PC and IF/ID when high.
REQ-012 bubble_cnt  out  CNT_W  number of bubbles inserted since reset.

Function
REQ-013 Normal update: stall=0, EX_flush=0 -> every EX_ output takes its ID_ value at the next rising edge (1-cycle latency).
REQ-014 Bubble: on a bubble edge, EX_ctrl=0 and EX_valid=0; data outputs SHALL hold their previous values.
REQ-015 Flush: EX_flush=1 -> bubble, regardless of ID_valid or stall.
REQ-016 Load-use: stall=1 iff EX_valid & EX_ctrl[1] & EX_rt!=0 & ID_valid & (EX_rt==ID_rs | (EX_rt==ID_rt & ID_ctrl[8]==0 | EX_rt==ID_rt & ID_ctrl[2])).
REQ-017 stall=1 -> bubble into EX; ID inputs are expected to be held upstream and are re-sampled next cycle.
REQ-018 Simultaneous stall and EX_flush -> single bubble; bubble_cnt increments by exactly 1.
REQ-019 Stall lasts exactly one cycle per load-use pair, since the bubble clears EX_ctrl[1].
REQ-020 ID_valid=0 with no stall or flush -> EX_valid=0 and EX_ctrl=0; this is not counted as a bubble.
REQ-021 bubble_cnt increments by 1 on each flush or stall edge and saturates at all-ones; no wrap-around.
REQ-022 State machine: RUN (normal update), BUBBLE (last edge inserted a bubble), HOLD_CHK (a stall bubble was inserted; the next cycle re-evaluates the held ID). Transitions:
  RUN->BUBBLE on flush; RUN->HOLD_CHK on stall; BUBBLE->RUN, HOLD_CHK->RUN otherwise.
  HOLD_CHK SHALL NOT assert stall on the same ID instruction twice.
REQ-023 The state register is internal and exists only for REQ-022 and REQ-019 checking.

Reset
REQ-024 On reset: EX_ctrl=0, EX_valid=0, all EX_ data outputs=0, bubble_cnt=0, state=RUN, and stall evaluates to 0.
REQ-025 Reset asserted mid-stall or mid-flush discards the pending instruction; the first post-reset edge performs a normal update.

Configuration
REQ-026 Macro LOAD_USE_STALL_EN defined -> REQ-016 to REQ-019 are active.
REQ-027 Macro not defined -> stall is tied to 0, HOLD_CHK is removed, only flush creates bubbles, and bubble_cnt counts flushes only.

Verification
REQ-028 Reset released, ID_valid=1, ID_ctrl=14'h0405, ID_rs_data=32'h11 -> next edge EX_ctrl=14'h0405, EX_rs_data=32'h11, EX_valid=1, stall=0.
REQ-029 lw with rt=8 in EX, then ID add with rs=8 -> stall=1 for one cycle, EX_valid=0, bubble_cnt=1; next edge add enters EX with stall=0.
REQ-030 lw with rt=0 in EX, then ID rs=0 -> stall=0 and no bubble.
REQ-031 EX_flush=1 together with a load-use condition -> one bubble, bubble_cnt +1 only.
REQ-032 Preload bubble_cnt to 16'hFFFE, then apply 3 flushes -> bubble_cnt reads 16'hFFFF and holds.
REQ-033 Assert reset asynchronously between edges during a stall -> all outputs are 0 immediately and stall=0; build without LOAD_USE_STALL_EN -> the REQ-029 stimulus gives stall=0.
